// File: rtl/frame_write_sequencer_if.sv
// Word-stream handshake between the bitstream word source and the frame write sequencer.
// A word transfers on a clock edge where WriteStrobe && Ready.
interface frame_write_sequencer_if;
  logic [31:0] WriteData;
  logic        WriteStrobe;
  logic        Ready;

  modport master (output WriteData, output WriteStrobe, input Ready);
  modport slave  (input WriteData, input WriteStrobe, output Ready);
endinterface

// File: rtl/frame_write_sequencer.sv
// Frame write sequencer: takes a header word and NumberOfRows data words, assembles the
// frame in a holding register, then issues a single-cycle column frame strobe followed by
// one gap cycle before accepting the next frame.
module frame_write_sequencer #(
  parameter int unsigned MaxFramesPerCol  = 20,
  parameter int unsigned FrameSelectWidth = 5,
  parameter int unsigned NumColumns       = 10,
  parameter int unsigned NumberOfRows     = 16
) (
  input  logic                          CLK,
  input  logic                          resetn,
  frame_write_sequencer_if.slave        wr_if,
  input  logic                          Abort,
  input  logic                          ClearError,
  output logic [32*NumberOfRows-1:0]    FrameData,
  output logic [FrameSelectWidth-1:0]   FrameSelect,
  output logic                          FrameStrobe,
  output logic [MaxFramesPerCol-1:0]    FrameStrobe_I,
  output logic                          Error,
  output logic [15:0]                   FramesWritten
);

  localparam int unsigned RowW = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STROBE,
    GAP
  } state_e;

  state_e                        state_q;
  logic                          ready_q;
  logic [RowW-1:0]               row_q;
  logic [4:0]                    idx_q;
  logic [FrameSelectWidth-1:0]   sel_q;
  logic [32*NumberOfRows-1:0]    frame_data_q;
  logic                          strobe_q;
  logic [MaxFramesPerCol-1:0]    strobe_vec_q;
  logic                          error_q;
  logic [15:0]                   frames_q;

  logic                          xfer_d;
  logic [4:0]                    hdr_col_d;
  logic [4:0]                    hdr_idx_d;
  logic                          hdr_ok_d;
  logic                          err_evt_d;

  // Header decode and error-event detection for the word presented this cycle.
  always_comb begin
    xfer_d    = wr_if.WriteStrobe && ready_q;
    hdr_col_d = wr_if.WriteData[20:16];
    hdr_idx_d = wr_if.WriteData[4:0];
    hdr_ok_d  = (32'(hdr_col_d) < NumColumns) && (32'(hdr_idx_d) < MaxFramesPerCol);
    err_evt_d = (state_q == IDLE) && !Abort && xfer_d && !(wr_if.WriteData[31] && hdr_ok_d);
  end

  // Sequencer FSM with registered handshake, strobe, data and status outputs.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      row_q        <= '0;
      idx_q        <= '0;
      sel_q        <= '0;
      frame_data_q <= '0;
      strobe_q     <= 1'b0;
      strobe_vec_q <= '0;
      error_q      <= 1'b0;
      frames_q     <= '0;
    end else begin
      error_q <= err_evt_d | (error_q & ~ClearError);
      unique case (state_q)
        IDLE: begin
          if (!Abort && xfer_d && wr_if.WriteData[31] && hdr_ok_d) begin
            sel_q   <= hdr_col_d[FrameSelectWidth-1:0];
            idx_q   <= hdr_idx_d;
            row_q   <= '0;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (Abort) begin
            state_q <= IDLE;
          end else if (xfer_d) begin
            for (int unsigned k = 0; k < NumberOfRows; k++) begin
              if (row_q == RowW'(k)) frame_data_q[32*k +: 32] <= wr_if.WriteData;
            end
            row_q <= row_q + 1'b1;
            if (row_q == RowW'(NumberOfRows - 1)) begin
              state_q      <= STROBE;
              ready_q      <= 1'b0;
              strobe_q     <= 1'b1;
              strobe_vec_q <= MaxFramesPerCol'(1) << idx_q;
            end
          end
        end
        STROBE: begin
          strobe_q     <= 1'b0;
          strobe_vec_q <= '0;
          state_q      <= GAP;
        end
        GAP: begin
          frames_q <= frames_q + 16'd1;
          ready_q  <= 1'b1;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign wr_if.Ready    = ready_q;
  assign FrameData      = frame_data_q;
  assign FrameSelect    = sel_q;
  assign FrameStrobe    = strobe_q;
  assign FrameStrobe_I  = strobe_vec_q;
  assign Error          = error_q;
  assign FramesWritten  = frames_q;

endmodule

// File: tb/tb_frame_write_sequencer.sv
// Self-checking bench for frame_write_sequencer: expected frames are queued when driven and
// compared when the DUT strobes them out; status outputs are checked after each scenario.
module tb_frame_write_sequencer;
  localparam int unsigned Rows = 16;
  localparam int unsigned MaxF = 20;
  localparam int unsigned NCol = 10;
  localparam int unsigned FSW  = 5;
  localparam int unsigned FDW  = 32 * Rows;

  typedef struct {
    logic [4:0]     col;
    logic [4:0]     idx;
    logic [FDW-1:0] data;
  } frame_t;

  logic            CLK = 1'b0;
  logic            resetn = 1'b0;
  logic            Abort = 1'b0;
  logic            ClearError = 1'b0;
  logic [FDW-1:0]  FrameData;
  logic [FSW-1:0]  FrameSelect;
  logic            FrameStrobe;
  logic [MaxF-1:0] FrameStrobe_I;
  logic            Error;
  logic [15:0]     FramesWritten;

  frame_write_sequencer_if wr_if ();

  frame_write_sequencer #(
    .MaxFramesPerCol (MaxF),
    .FrameSelectWidth(FSW),
    .NumColumns      (NCol),
    .NumberOfRows    (Rows)
  ) dut (
    .CLK          (CLK),
    .resetn       (resetn),
    .wr_if        (wr_if.slave),
    .Abort        (Abort),
    .ClearError   (ClearError),
    .FrameData    (FrameData),
    .FrameSelect  (FrameSelect),
    .FrameStrobe  (FrameStrobe),
    .FrameStrobe_I(FrameStrobe_I),
    .Error        (Error),
    .FramesWritten(FramesWritten)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_errors = 0;
  frame_t      sb_q[$];
  logic [FDW-1:0] mdl_fd = '0;
  logic [15:0] exp_frames = '0;
  int unsigned cyc = 0;
  int unsigned last_word_cyc = 0;
  int unsigned low_run = 0;

  task automatic check(input string tag, input logic [FDW-1:0] got, input logic [FDW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Monitor: strobe scoreboard, idle strobe vector, and Ready-low run length.
  initial forever begin
    @(negedge CLK);
    if (!resetn) begin
      low_run = 0;
    end else begin
      if (!wr_if.Ready) low_run++;
      else if (low_run != 0) begin
        check("ready_low_cycles", low_run, 2);
        low_run = 0;
      end
      if (FrameStrobe) begin
        if (sb_q.size() == 0) check("unexpected_strobe", 1, 0);
        else begin
          frame_t e;
          logic [MaxF-1:0] onehot;
          e = sb_q.pop_front();
          onehot = '0;
          onehot[e.idx] = 1'b1;
          check("frame_select", FrameSelect, e.col);
          check("frame_strobe_i", FrameStrobe_I, onehot);
          check("frame_data", FrameData, e.data);
          check("strobe_cycle", cyc, last_word_cyc);
        end
      end else begin
        check("strobe_i_idle", FrameStrobe_I, 0);
      end
    end
  end

  task automatic send_word(input logic [31:0] w);
    int unsigned n;
    n = 0;
    @(negedge CLK);
    wr_if.WriteData   = w;
    wr_if.WriteStrobe = 1'b1;
    while (!wr_if.Ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("ready_wait", wr_if.Ready, 1);
    @(posedge CLK);
    #1;
    wr_if.WriteStrobe = 1'b0;
    last_word_cyc     = cyc;
  endtask

  task automatic send_frame(input logic [4:0] col, input logic [4:0] idx,
                            input logic [31:0] base, input bit gapped, input bit push);
    frame_t f;
    f.col  = col;
    f.idx  = idx;
    f.data = mdl_fd;
    for (int k = 0; k < int'(Rows); k++) f.data[32*k +: 32] = base + 32'(k);
    if (push) sb_q.push_back(f);
    send_word(32'h8000_0000 | {11'b0, col, 16'b0} | {27'b0, idx});
    for (int k = 0; k < int'(Rows); k++) begin
      if (gapped) repeat ($urandom_range(0, 2)) @(negedge CLK);
      send_word(base + 32'(k));
    end
    mdl_fd = f.data;
  endtask

  task automatic wait_ready_and_count();
    int unsigned n;
    n = 0;
    @(negedge CLK);
    while (!wr_if.Ready && n < 10) begin
      @(negedge CLK);
      n++;
    end
    check("ready_return", wr_if.Ready, 1);
    exp_frames = exp_frames + 16'd1;
    check("frames_written", FramesWritten, exp_frames);
  endtask

  task automatic pulse_clear_error();
    @(negedge CLK);
    ClearError = 1'b1;
    @(posedge CLK);
    #1;
    ClearError = 1'b0;
  endtask

  initial begin
    int unsigned n;
    wr_if.WriteData   = '0;
    wr_if.WriteStrobe = 1'b0;

    repeat (2) @(negedge CLK);
    resetn = 1'b1;
    @(negedge CLK);
    check("rst_ready", wr_if.Ready, 1);
    check("rst_frame_data", FrameData, 0);
    check("rst_frame_select", FrameSelect, 0);
    check("rst_strobe", FrameStrobe, 0);
    check("rst_strobe_i", FrameStrobe_I, 0);
    check("rst_error", Error, 0);
    check("rst_frames", FramesWritten, 0);

    // Basic write: col 3, frame 7
    send_frame(5'd3, 5'd7, 32'h1000_0000, 1'b0, 1'b1);
    wait_ready_and_count();

    // Bad headers
    send_word(32'h800A_0000);
    check("bad_col_error", Error, 1);
    check("bad_col_idle", wr_if.Ready, 1);
    send_word(32'h8000_0014);
    check("bad_frame_error", Error, 1);
    send_word(32'h0000_0001);
    check("data_in_idle_error", Error, 1);
    check("bad_no_data_change", FrameData, mdl_fd);
    pulse_clear_error();
    check("clear_error", Error, 0);
    @(negedge CLK);
    ClearError        = 1'b1;
    wr_if.WriteData   = 32'h800A_0000;
    wr_if.WriteStrobe = 1'b1;
    @(posedge CLK);
    #1;
    ClearError        = 1'b0;
    wr_if.WriteStrobe = 1'b0;
    check("clear_vs_new_error", Error, 1);
    pulse_clear_error();
    check("clear_error_2", Error, 0);

    // Boundary: highest valid column and frame index
    send_frame(5'd9, 5'd19, 32'h5A00_0000, 1'b0, 1'b1);
    wait_ready_and_count();

    // Gapped stream reproduces the basic frame
    send_frame(5'd3, 5'd7, 32'h1000_0000, 1'b1, 1'b1);
    wait_ready_and_count();

    // Abort after 5 data words
    send_word(32'h8002_0004);
    for (int k = 0; k < 5; k++) begin
      send_word(32'h2000_0000 + 32'(k));
      mdl_fd[32*k +: 32] = 32'h2000_0000 + 32'(k);
    end
    @(negedge CLK);
    Abort             = 1'b1;
    wr_if.WriteData   = 32'h2000_0005;
    wr_if.WriteStrobe = 1'b1;
    @(posedge CLK);
    #1;
    Abort             = 1'b0;
    wr_if.WriteStrobe = 1'b0;
    check("abort_ready", wr_if.Ready, 1);
    check("abort_partial_data", FrameData, mdl_fd);
    check("abort_frames", FramesWritten, exp_frames);
    check("abort_error_clear", Error, 0);
    send_word(32'h0000_0001);
    check("abort_now_idle", Error, 1);
    check("abort_word_dropped", FrameData, mdl_fd);
    pulse_clear_error();
    send_frame(5'd0, 5'd0, 32'h4000_0000, 1'b0, 1'b1);
    wait_ready_and_count();

    // Reset during STROBE
    send_frame(5'd5, 5'd2, 32'h3000_0000, 1'b0, 1'b0);
    check("strobe_before_reset", FrameStrobe, 1);
    #1;
    resetn = 1'b0;
    #1;
    check("rst_mid_strobe", FrameStrobe, 0);
    check("rst_mid_strobe_i", FrameStrobe_I, 0);
    check("rst_mid_data", FrameData, 0);
    check("rst_mid_frames", FramesWritten, 0);
    check("rst_mid_ready", wr_if.Ready, 1);
    repeat (2) @(negedge CLK);
    resetn     = 1'b1;
    mdl_fd     = '0;
    exp_frames = '0;

    // Counter wrap from 0xFFFF
    @(negedge CLK);
    force dut.frames_q = 16'hFFFF;
    #1;
    release dut.frames_q;
    exp_frames = 16'hFFFF;
    check("preset_frames", FramesWritten, exp_frames);
    send_frame(5'd1, 5'd10, 32'h6000_0000, 1'b0, 1'b1);
    wait_ready_and_count();
    check("wrap_zero", FramesWritten, 0);

    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("scoreboard_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
